// File: rtl/stop_it_pkg.sv
// Shared types and constants for the seven-segment scanner.
package stop_it_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low one-hot anode select for a digit index
    function automatic logic [3:0] anode_onehot_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
    import stop_it_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup of the cathode pattern for each hex value
    always_comb begin
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner with per-slot anti-ghost
// blanking. Each digit is snapshotted at the start of its slot so mid-slot
// input changes never tear the displayed value. Outputs are registered and
// computed from next-state values, so output timing lines up with the counter.
module seven_seg_scanner
    import stop_it_pkg::*;
#(
    parameter int SLOT_CYCLES  = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       digit0_en_i,
    input  logic       digit1_en_i,
    input  logic       digit2_en_i,
    input  logic       digit3_en_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    output logic [3:0] anode_o,
    output logic [6:0] segments_o,
    output logic       dp_o,
    output logic       frame_o
);

    localparam int              CNT_W      = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    scan_state_t      state_q, state_d;
    logic             snap_en_q, snap_en_d;
    logic [3:0]       snap_val_q, snap_val_d;
    logic [3:0]       anode_q, anode_d;
    logic [6:0]       seg_q, seg_d;
    logic             frame_q, frame_d;

    logic             cur_en_s;
    logic [3:0]       cur_val_s;
    logic [6:0]       dec_seg_s;

    // Select the enable/value of the digit whose slot is current
    always_comb begin
        cur_en_s  = 1'b0;
        cur_val_s = 4'h0;
        case (idx_q)
            2'd0:    begin cur_en_s = digit0_en_i; cur_val_s = digit0_i; end
            2'd1:    begin cur_en_s = digit1_en_i; cur_val_s = digit1_i; end
            2'd2:    begin cur_en_s = digit2_en_i; cur_val_s = digit2_i; end
            2'd3:    begin cur_en_s = digit3_en_i; cur_val_s = digit3_i; end
            default: begin cur_en_s = 1'b0;        cur_val_s = 4'h0;     end
        endcase
    end

    hex7seg u_hex7seg (
        .hex_i (snap_val_d),
        .seg_o (dec_seg_s)
    );

    // Next-state logic: slot counter, digit index, FSM, snapshot and outputs
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        state_d    = state_q;
        snap_en_d  = snap_en_q;
        snap_val_d = snap_val_q;
        anode_d    = AN_OFF;
        seg_d      = SEG_OFF;
        frame_d    = 1'b0;

        if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end

        case (state_q)
            BLANK:   state_d = (cnt_q == BLANK_LAST) ? DRIVE : BLANK;
            DRIVE:   state_d = (cnt_q == CNT_LAST)   ? BLANK : DRIVE;
            default: state_d = BLANK;
        endcase

        // Capture during the first blank cycle; the hex decoder sees the
        // fresh snapshot so even a one-cycle blank window works.
        if ((state_q == BLANK) && (cnt_q == CNT_ZERO)) begin
            snap_en_d  = cur_en_s;
            snap_val_d = cur_val_s;
        end else begin
            snap_en_d  = snap_en_q;
            snap_val_d = snap_val_q;
        end

        if ((state_d == DRIVE) && snap_en_d) begin
            anode_d = anode_onehot_n(idx_d);
            seg_d   = dec_seg_s;
        end else begin
            anode_d = AN_OFF;
            seg_d   = SEG_OFF;
        end

        frame_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q      <= CNT_ZERO;
            idx_q      <= 2'd0;
            state_q    <= BLANK;
            snap_en_q  <= 1'b0;
            snap_val_q <= 4'h0;
            anode_q    <= AN_OFF;
            seg_q      <= SEG_OFF;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            snap_en_q  <= snap_en_d;
            snap_val_q <= snap_val_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
            frame_q    <= frame_d;
        end
    end

    assign anode_o    = anode_q;
    assign segments_o = seg_q;
    assign frame_o    = frame_q;
    assign dp_o       = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (SLOT_CYCLES=8, BLANK_CYCLES=2).
module tb_seven_seg_scanner;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] d_en;
    logic [3:0] d_val [4];
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    int checks = 0;
    int errors = 0;

    // Independent copy of the decode table
    logic [6:0] lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seven_seg_scanner #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .digit0_en_i (d_en[0]),
        .digit1_en_i (d_en[1]),
        .digit2_en_i (d_en[2]),
        .digit3_en_i (d_en[3]),
        .digit0_i    (d_val[0]),
        .digit1_i    (d_val[1]),
        .digit2_i    (d_val[2]),
        .digit3_i    (d_val[3]),
        .anode_o     (anode),
        .segments_o  (seg),
        .dp_o        (dp),
        .frame_o     (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_t is the cycle count since the last reset edge; slot position
    // and digit index follow by division. Each slot latches its digit's
    // inputs as they stand during the slot's first cycle.
    int         m_t = 0;
    logic       m_snap_en = 1'b0;
    logic [3:0] m_snap_val = 4'h0;
    logic       checking = 1'b0;
    int         frame_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_t        <= 0;
            m_snap_en  <= 1'b0;
            m_snap_val <= 4'h0;
            checking   <= 1'b1;
        end else begin
            m_t <= m_t + 1;
            if (m_t % SLOT == 0) begin
                m_snap_en  <= d_en[(m_t / SLOT) % 4];
                m_snap_val <= d_val[(m_t / SLOT) % 4];
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int         c;
        int         i;
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fr;
        if (checking) begin
            c       = m_t % SLOT;
            i       = (m_t / SLOT) % 4;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            if (c >= BLANK && m_snap_en) begin
                one     = 4'b0001 << i;
                exp_an  = ~one;
                exp_seg = lut[m_snap_val];
            end
            exp_fr = (i == 3) && (c == SLOT - 1);
            chk("model_anode", 32'(anode), 32'(exp_an));
            chk("model_seg", 32'(seg), 32'(exp_seg));
            chk("model_dp", 32'(dp), 32'd1);
            chk("model_frame", 32'(frame), 32'(exp_fr));
            if (frame === 1'b1 && m_t < 64) frame_cnt++;
        end
    end

    // Advance to the negedge of model cycle k, bounded
    task automatic goto(input int k);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (m_t == k) return;
        end
        chk("goto_timeout", 32'(m_t), 32'(k));
    endtask

    initial begin
        rst_n    = 1'b0;
        d_en     = 4'b1101;
        d_val[0] = 4'hF;
        d_val[1] = 4'h5;
        d_val[2] = 4'h3;
        d_val[3] = 4'hA;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_anode", 32'(anode), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_frame", 32'(frame), 32'd0);
        rst_n = 1'b1;

        goto(1);
        chk("c1_blank_anode", 32'(anode), 32'h0000000F);
        goto(2);
        chk("c2_anode", 32'(anode), 32'h0000000E);
        chk("c2_seg_F", 32'(seg), 32'h0000000E);
        goto(7);
        chk("c7_seg_F", 32'(seg), 32'h0000000E);
        goto(10);
        chk("slot1_off_anode", 32'(anode), 32'h0000000F);
        chk("slot1_off_seg", 32'(seg), 32'h0000007F);
        goto(19);
        chk("slot2_anode", 32'(anode), 32'h0000000B);
        goto(20);
        chk("slot2_seg_3", 32'(seg), 32'h00000030);
        d_val[2] = 4'h8;
        goto(23);
        chk("slot2_held_3", 32'(seg), 32'h00000030);
        goto(26);
        chk("slot3_anode", 32'(anode), 32'h00000007);
        chk("slot3_seg_A", 32'(seg), 32'h00000008);
        goto(30);
        chk("frame_c30", 32'(frame), 32'd0);
        goto(31);
        chk("frame_c31", 32'(frame), 32'd1);
        goto(50);
        chk("slot2b_anode", 32'(anode), 32'h0000000B);
        chk("slot2b_seg_8", 32'(seg), 32'h00000000);
        goto(63);
        chk("frame_c63", 32'(frame), 32'd1);
        goto(64);
        chk("frame_count", 32'(frame_cnt), 32'd2);
        chk("wrap_blank", 32'(anode), 32'h0000000F);
        goto(66);
        chk("wrap_anode", 32'(anode), 32'h0000000E);

        goto(85);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_anode", 32'(anode), 32'h0000000F);
        chk("midrst_seg", 32'(seg), 32'h0000007F);
        chk("midrst_frame", 32'(frame), 32'd0);
        rst_n = 1'b1;
        goto(2);
        chk("post_rst_anode", 32'(anode), 32'h0000000E);
        chk("post_rst_seg", 32'(seg), 32'h0000000E);
        goto(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
